// File: rtl/ship_draw_controller.sv
// ship_draw_controller
// Sequences player-ship redraws into the single VGA framebuffer write port.
// On a frame tick where the ship x position changed, the old sprite
// rectangle is erased with the background colour and the sprite is then
// drawn at the new origin, one pixel per cycle in row-major order. The write
// port is shared with one external drawer through a req/gnt handshake.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle redraw request pulse
//   x_val       requested sprite x origin (values above X_MAX are clamped)
//   ext_req     external drawer requests the write port
//   ext_gnt     external drawer owns the write port (registered)
//   vga_x       pixel x (registered)
//   vga_y       pixel y (registered)
//   vga_colour  pixel colour (registered)
//   vga_plot    write strobe (registered)
//   busy        high while erasing or drawing
//
// Optional feature macro: SHIP_BITMAP_EN
//   Defined:   DRAW plots only the triangle mask; masked-off pixels still
//              take their cycle with vga_plot low. ERASE is unchanged.
//   Undefined: DRAW fills the solid SPRITE_W x SPRITE_H rectangle.

module ship_draw_controller #(
  parameter int          SPRITE_W    = 8,
  parameter int          SPRITE_H    = 8,
  parameter int          SHIP_Y      = 112,
  parameter int          X_MAX       = 120,
  parameter logic [2:0]  SHIP_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [7:0] x_val,
  input  logic       ext_req,
  output logic       ext_gnt,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);
  localparam logic [7:0]    X_LIMIT  = 8'(X_MAX);
  localparam logic [6:0]    Y_BASE   = 7'(SHIP_Y);

  typedef enum logic [1:0] {IDLE, GRANT, ERASE, DRAW} state_e;

  state_e          state_q, state_d;
  logic            pending_q, pending_d;
  logic            drawn_valid_q, drawn_valid_d;
  logic [7:0]      cur_x_q, cur_x_d;
  logic [7:0]      new_x_q, new_x_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;

  logic            ext_gnt_q, ext_gnt_d;
  logic [7:0]      vga_x_q, vga_x_d;
  logic [6:0]      vga_y_q, vga_y_d;
  logic [2:0]      vga_colour_q, vga_colour_d;
  logic            vga_plot_q, vga_plot_d;
  logic            busy_q, busy_d;

  logic [7:0]      clamp_x;
  logic            last_pix;
  logic [7:0]      x_base;
  logic            draw_mask;

  assign clamp_x  = (x_val > X_LIMIT) ? X_LIMIT : x_val;
  assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // State register plus all datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      drawn_valid_q <= 1'b0;
      cur_x_q       <= '0;
      new_x_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      ext_gnt_q     <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      drawn_valid_q <= drawn_valid_d;
      cur_x_q       <= cur_x_d;
      new_x_q       <= new_x_d;
      row_q         <= row_d;
      col_q         <= col_d;
      ext_gnt_q     <= ext_gnt_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic. A redraw request beats ext_req in IDLE; ticks seen
  // anywhere else collapse into the single pending flag. The pixel counters
  // run only in ERASE/DRAW and wrap to zero on the last pixel, which also
  // starts DRAW at pixel 0 straight after ERASE.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    drawn_valid_d = drawn_valid_q;
    cur_x_d       = cur_x_q;
    new_x_d       = new_x_q;
    row_d         = '0;
    col_d         = '0;
    case (state_q)
      IDLE: begin
        if (frame_tick || pending_q) begin
          pending_d = 1'b0;
          new_x_d   = clamp_x;
          if (drawn_valid_q && (clamp_x == cur_x_q)) state_d = IDLE;
          else if (drawn_valid_q)                     state_d = ERASE;
          else                                        state_d = DRAW;
        end else if (ext_req) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (frame_tick) pending_d = 1'b1;
        if (!ext_req)   state_d   = IDLE;
      end
      ERASE, DRAW: begin
        if (frame_tick) pending_d = 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
          row_d = row_q;
        end
        if (last_pix) begin
          if (state_q == ERASE) begin
            state_d = DRAW;
          end else begin
            state_d       = IDLE;
            cur_x_d       = new_x_q;
            drawn_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SHIP_BITMAP_EN
  int half_row;
  // Triangle mask: row r covers cols (3 - r/2) .. (4 + r/2).
  always_comb begin
    half_row  = int'(row_d) / 2;
    draw_mask = (int'(col_d) >= 3 - half_row) && (int'(col_d) <= 4 + half_row);
  end
`else
  assign draw_mask = 1'b1;
`endif

  // Output logic. Outputs are computed from the next state and counters so
  // the registered pixel lands in the cycle its state/counter is current;
  // the first pixel therefore appears the cycle after a tick is accepted.
  always_comb begin
    ext_gnt_d    = (state_q == GRANT) && ext_req;
    busy_d       = (state_d == ERASE) || (state_d == DRAW);
    x_base       = (state_d == ERASE) ? cur_x_q : new_x_d;
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    vga_plot_d   = 1'b0;
    if (busy_d) begin
      vga_x_d      = x_base + 8'(col_d);
      vga_y_d      = Y_BASE + 7'(row_d);
      vga_colour_d = (state_d == ERASE) ? BG_COLOUR : SHIP_COLOUR;
      vga_plot_d   = (state_d == ERASE) ? 1'b1 : draw_mask;
    end
  end

  assign ext_gnt    = ext_gnt_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ship_draw_controller.sv
// tb_ship_draw_controller
// Directed self-checking bench for ship_draw_controller. Each scenario task
// drives its stimulus and compares observed outputs with hand-derived
// values. Outputs are sampled on the falling clock edge.
// Honours SHIP_BITMAP_EN for the expected draw mask.

module tb_ship_draw_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [7:0] x_val;
  logic       ext_req;
  logic       ext_gnt;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

`ifdef SHIP_BITMAP_EN
  localparam int DRAW_N = 40;
`else
  localparam int DRAW_N = 64;
`endif

  int checks = 0;
  int errors = 0;

  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  int busy_cnt, busy_rises, first_busy, last_plot_idx, max_x;
  logic prev_busy;

  ship_draw_controller dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .x_val      (x_val),
    .ext_req    (ext_req),
    .ext_gnt    (ext_gnt),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic bit mask_bit(input int r, input int c);
`ifdef SHIP_BITMAP_EN
    return (c >= 3 - r / 2) && (c <= 4 + r / 2);
`else
    return 1'b1;
`endif
  endfunction

  // Expected pixel stream: optional full erase at ex, then masked draw at dx.
  task automatic build_exp(input bit do_erase, input int ex, input int dx);
    exp_q.delete();
    if (do_erase)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          exp_q.push_back({8'(ex + c), 7'(112 + r), 3'b000});
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (mask_bit(r, c)) exp_q.push_back({8'(dx + c), 7'(112 + r), 3'b111});
  endtask

  function automatic int count_diffs();
    int d = 0;
    int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) d++;
    d += (got.size() > exp_q.size()) ? got.size() - exp_q.size() : exp_q.size() - got.size();
    return d;
  endfunction

  // Called at a falling edge: drives tick/x, then samples n falling edges.
  task automatic run_window(input logic tick, input logic [7:0] x, input int n);
    got.delete();
    busy_cnt = 0; busy_rises = 0; first_busy = -1; last_plot_idx = -1; max_x = 0;
    prev_busy = busy;
    frame_tick = tick;
    x_val = x;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      frame_tick = 1'b0;
      if (i == 2) x_val = x ^ 8'h5A;
      if (busy) begin
        busy_cnt++;
        if (!prev_busy) begin
          busy_rises++;
          if (first_busy < 0) first_busy = i;
        end
      end
      prev_busy = busy;
      if (vga_plot) begin
        got.push_back({vga_x, vga_y, vga_colour});
        last_plot_idx = i;
        if (int'(vga_x) > max_x) max_x = int'(vga_x);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; ext_req = 1'b0; x_val = 8'd0;
    repeat (3) @(negedge clock);
    checks++;
    if (vga_plot !== 1'b0) begin errors++; $display("[TB] FAIL reset_plot got %b want 0", vga_plot); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (ext_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt got %b want 0", ext_gnt); end
    checks++;
    if ({vga_x, vga_y, vga_colour} !== 18'd0)
      begin errors++; $display("[TB] FAIL reset_pixel got %h want 0", {vga_x, vga_y, vga_colour}); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_first_draw();
    run_window(1'b1, 8'd10, 100);
    build_exp(1'b0, 0, 10);
    checks++;
    if (count_diffs() !== 0)
      begin errors++; $display("[TB] FAIL first_draw_pixels diffs %0d got_n %0d want_n %0d", count_diffs(), got.size(), exp_q.size()); end
    checks++;
    if (got.size() !== DRAW_N) begin errors++; $display("[TB] FAIL first_draw_count got %0d want %0d", got.size(), DRAW_N); end
    checks++;
    if (busy_cnt !== 64 || busy_rises !== 1)
      begin errors++; $display("[TB] FAIL first_draw_busy got %0d/%0d want 64/1", busy_cnt, busy_rises); end
    checks++;
    if (first_busy !== 0) begin errors++; $display("[TB] FAIL first_pixel_latency got %0d want 0", first_busy); end
    checks++;
    if (last_plot_idx !== 63) begin errors++; $display("[TB] FAIL plot_deassert got %0d want 63", last_plot_idx); end
  endtask

  task automatic test_move();
    run_window(1'b1, 8'd11, 200);
    build_exp(1'b1, 10, 11);
    checks++;
    if (count_diffs() !== 0)
      begin errors++; $display("[TB] FAIL move_pixels diffs %0d got_n %0d want_n %0d", count_diffs(), got.size(), exp_q.size()); end
    checks++;
    if (busy_cnt !== 128 || busy_rises !== 1)
      begin errors++; $display("[TB] FAIL move_busy got %0d/%0d want 128/1", busy_cnt, busy_rises); end
  endtask

  task automatic test_no_move();
    run_window(1'b1, 8'd11, 20);
    checks++;
    if (got.size() !== 0) begin errors++; $display("[TB] FAIL no_move_plots got %0d want 0", got.size()); end
    checks++;
    if (busy_cnt !== 0) begin errors++; $display("[TB] FAIL no_move_busy got %0d want 0", busy_cnt); end
  endtask

  task automatic test_clamp();
    run_window(1'b1, 8'd200, 200);
    build_exp(1'b1, 11, 120);
    checks++;
    if (count_diffs() !== 0)
      begin errors++; $display("[TB] FAIL clamp_pixels diffs %0d got_n %0d want_n %0d", count_diffs(), got.size(), exp_q.size()); end
    checks++;
    if (max_x !== 127) begin errors++; $display("[TB] FAIL clamp_max_x got %0d want 127", max_x); end
  endtask

  task automatic test_starvation();
    int stray;
    stray = 0;
    ext_req = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (ext_gnt !== 1'b1) begin errors++; $display("[TB] FAIL starve_gnt_rise got %b want 1", ext_gnt); end
    x_val = 8'd50;
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      if (vga_plot || busy) stray++;
      repeat (2) begin
        @(negedge clock);
        if (vga_plot || busy) stray++;
      end
    end
    checks++;
    if (stray !== 0 || ext_gnt !== 1'b1)
      begin errors++; $display("[TB] FAIL starve_hold stray %0d gnt %b want 0 1", stray, ext_gnt); end
    ext_req = 1'b0;
    @(negedge clock);
    checks++;
    if (ext_gnt !== 1'b0) begin errors++; $display("[TB] FAIL starve_gnt_fall got %b want 0", ext_gnt); end
    run_window(1'b0, 8'd50, 200);
    build_exp(1'b1, 120, 50);
    checks++;
    if (count_diffs() !== 0)
      begin errors++; $display("[TB] FAIL starve_redraw diffs %0d got_n %0d want_n %0d", count_diffs(), got.size(), exp_q.size()); end
    checks++;
    if (busy_cnt !== 128 || busy_rises !== 1)
      begin errors++; $display("[TB] FAIL starve_single_redraw got %0d/%0d want 128/1", busy_cnt, busy_rises); end
  endtask

  task automatic test_simultaneous();
    int last_busy, first_gnt, nplot;
    last_busy = -1; first_gnt = -1; nplot = 0;
    frame_tick = 1'b1; ext_req = 1'b1; x_val = 8'd60;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      frame_tick = 1'b0;
      if (busy) last_busy = i;
      if (vga_plot) nplot++;
      if (ext_gnt && first_gnt < 0) first_gnt = i;
      if (first_gnt >= 0) break;
    end
    checks++;
    if (last_busy !== 127) begin errors++; $display("[TB] FAIL simul_last_busy got %0d want 127", last_busy); end
    checks++;
    if (first_gnt !== 130) begin errors++; $display("[TB] FAIL simul_first_gnt got %0d want 130", first_gnt); end
    checks++;
    if (nplot !== 64 + DRAW_N) begin errors++; $display("[TB] FAIL simul_plots got %0d want %0d", nplot, 64 + DRAW_N); end
    ext_req = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_erase();
    x_val = 8'd70; frame_tick = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clock);
      frame_tick = 1'b0;
    end
    // Pixel 30 of the erase of the sprite at 60: row 3, col 6.
    checks++;
    if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd66, 7'd115, 3'd0})
      begin errors++; $display("[TB] FAIL mid_erase_pixel got %h want %h", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd66, 7'd115, 3'd0}); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (vga_plot !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL mid_reset_idle plot %b busy %b want 0 0", vga_plot, busy); end
    reset = 1'b0;
    run_window(1'b1, 8'd70, 150);
    build_exp(1'b0, 0, 70);
    checks++;
    if (count_diffs() !== 0)
      begin errors++; $display("[TB] FAIL post_reset_draw diffs %0d got_n %0d want_n %0d", count_diffs(), got.size(), exp_q.size()); end
    checks++;
    if (busy_cnt !== 64) begin errors++; $display("[TB] FAIL post_reset_busy got %0d want 64", busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_move();
    test_no_move();
    test_clamp();
    test_starvation();
    test_simultaneous();
    test_reset_mid_erase();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
